// File: rtl/ram_rwsp_pkg.sv
// Shared sizing and types for the 128x6 read/write single-port register-file RAM.
package ram_rwsp_pkg;
    localparam int RAM_DEPTH = 128;
    localparam int RAM_WIDTH = 6;
    localparam int RAM_AW    = 7;

    typedef logic [RAM_AW-1:0]    addr_t;
    typedef logic [RAM_WIDTH-1:0] data_t;
endpackage

// File: rtl/ram_rwsp_array.sv
// 128x6 flop storage: one synchronous write port, one combinational read mux.
module ram_rwsp_array
    import ram_rwsp_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t wa,
    input  data_t di,
    input  addr_t ra,
    output data_t rd
);
    // Storage is deliberately not reset; contents survive a reset.
    logic [RAM_DEPTH-1:0][RAM_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= di;
    end

    assign rd = mem[ra];
endmodule

// File: rtl/ram_rwsp_d128_w6.sv
// 128x6 RAM with two-stage read (address capture on re, output load on ore).
// Optional simulation contention check enabled by defining RAM_CONTENTION_CHECK_EN.
module ram_rwsp_d128_w6
    import ram_rwsp_pkg::*;
#(
    parameter bit FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pwrbus_ram_pd,
    input  addr_t       wa,
    input  logic        we,
    input  data_t       di,
    input  addr_t       ra,
    input  logic        re,
    input  logic        ore,
    output data_t       dout
);
    addr_t ra_d;
    data_t rd;
    logic  wr_en;

    // Reset outranks writes so a reset cycle never disturbs stored data.
    assign wr_en = we & ~reset;

    ram_rwsp_array u_array (
        .clk (clk),
        .we  (wr_en),
        .wa  (wa),
        .di  (di),
        .ra  (ra_d),
        .rd  (rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ra_d <= '0;
            dout <= '0;
        end else begin
            if (re)
                ra_d <= ra;
            // Write-first: a write landing on the same edge wins over stored data.
            if (ore)
                dout <= (wr_en && wa == ra_d) ? di : rd;
        end
    end

    // Power-bus hook is reserved and has no functional effect.
    logic unused_ok;
    assign unused_ok = ^{pwrbus_ram_pd, FORCE_CONTENTION_ASSERTION_RESET_ACTIVE};

`ifdef RAM_CONTENTION_CHECK_EN
    always @(posedge clk) begin
        if (we && re && wa == ra && (!reset || FORCE_CONTENTION_ASSERTION_RESET_ACTIVE))
            $error("ram_rwsp_d128_w6: write/read contention at address %0d", wa);
    end
`endif
endmodule

// File: tb/tb_ram_rwsp_d128_w6.sv
// Directed bench: array-based reference model checked every cycle, plus literal expectations.
module tb_ram_rwsp_d128_w6;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pwrbus_ram_pd = '0;
    logic [6:0]  wa = '0, ra = '0;
    logic        we = 1'b0, re = 1'b0, ore = 1'b0;
    logic [5:0]  di = '0;
    logic [5:0]  dout;

    int total = 0;
    int bad   = 0;

    ram_rwsp_d128_w6 dut (
        .clk           (clk),
        .reset         (reset),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .wa            (wa),
        .we            (we),
        .di            (di),
        .ra            (ra),
        .re            (re),
        .ore           (ore),
        .dout          (dout)
    );

    always #5 clk = ~clk;

    // Reference: plain array plus captured address and output value.
    logic [5:0] m_mem [128];
    logic [6:0] m_ra   = '0;
    logic [5:0] m_dout = '0;
    initial foreach (m_mem[i]) m_mem[i] = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_ra   = '0;
            m_dout = '0;
        end else begin
            if (ore) m_dout = (we && wa == m_ra) ? di : m_mem[m_ra];
            if (re)  m_ra = ra;
            if (we)  m_mem[wa] = di;
        end
    end

    always @(negedge clk) begin
        total++;
        if (dout !== m_dout) begin
            bad++;
            $display("FAIL model_cmp t=%0t dout=%h expected=%h", $time, dout, m_dout);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [5:0] exp);
        total++;
        if (dout !== exp) begin
            bad++;
            $display("FAIL %s dout=%h expected=%h", name, dout, exp);
        end
    endtask

    task automatic idle();
        we = 0; re = 0; ore = 0;
    endtask

    initial begin
        @(negedge clk);
        // 1: reset with everything asserted; the write must be ignored.
        reset = 1; re = 1; ore = 1; ra = 7'd55; we = 1; wa = 7'd0; di = 6'h3F;
        tick(); tick();
        lit("rst_dout", 6'h00);
        reset = 0; idle(); ore = 1;
        tick();
        lit("rst_read0", 6'h00);

        // 2: basic write, capture, load, hold.
        idle(); we = 1; wa = 7'd5; di = 6'h2A; tick();
        idle(); re = 1; ra = 7'd5; tick();
        idle(); ore = 1; tick();
        lit("basic_rd", 6'h2A);
        idle(); re = 1; ra = 7'd0; we = 1; wa = 7'd1; di = 6'h07;
        for (int k = 0; k < 3; k++) begin
            tick();
            lit("basic_hold", 6'h2A);
        end

        // 3: full sweep, pipelined read-back (ore loads previous capture).
        idle();
        for (int i = 0; i < 128; i++) begin
            we = 1; wa = 7'(i); di = 6'(i) ^ 6'h15; tick();
        end
        idle();
        for (int i = 0; i <= 128; i++) begin
            re = (i < 128); ra = 7'(i % 128); ore = (i > 0);
            tick();
            if (i > 0) lit("sweep", 6'(i - 1) ^ 6'h15);
        end
        idle(); re = 1; ra = 7'd0; tick();
        idle(); ore = 1; tick();
        lit("wrap_0", 6'h15);

        // 4: write-first through capture edge, plus same-edge write at load.
        pwrbus_ram_pd = 32'hFFFF_FFFF;
        idle(); we = 1; wa = 7'd9; di = 6'h01; tick();
        idle(); re = 1; ra = 7'd9; we = 1; wa = 7'd9; di = 6'h3F; tick();
        idle(); ore = 1; tick();
        lit("wf_capture", 6'h3F);
        idle(); re = 1; ra = 7'd12; tick();
        idle(); ore = 1; we = 1; wa = 7'd12; di = 6'h2D; tick();
        lit("wf_same_edge", 6'h2D);

        // 5: stall with an intervening write.
        idle(); we = 1; wa = 7'd3; di = 6'h11; tick();
        idle(); re = 1; ra = 7'd3; tick();
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k == 1) begin we = 1; wa = 7'd7; di = 6'h22; end
            tick();
            lit("stall_hold", 6'h2D);
        end
        idle(); ore = 1; tick();
        lit("stall_rd3", 6'h11);
        idle(); re = 1; ra = 7'd7; tick();
        idle(); ore = 1; tick();
        lit("stall_rd7", 6'h22);

        // Mid-run reset: clears dout, keeps contents, blocks writes.
        idle(); reset = 1; we = 1; wa = 7'd7; di = 6'h0F; ore = 1; tick();
        lit("rst2_dout", 6'h00);
        reset = 0; idle(); re = 1; ra = 7'd7; tick();
        idle(); ore = 1; tick();
        lit("rst2_keep", 6'h22);

        idle(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
